// File: rtl/thermal_guard_pkg.sv
// Shared types for the thermal guard: FSM state encoding and the sample class.
package thermal_guard_pkg;

  typedef enum logic [1:0] {
    NORMAL     = 2'd0,
    PENDING    = 2'd1,
    OVERHEATED = 2'd2,
    COOLING    = 2'd3
  } guard_state_t;

  typedef enum logic [1:0] {
    CLS_COOL = 2'd0,
    CLS_BAND = 2'd1,
    CLS_HOT  = 2'd2
  } sample_class_t;

endpackage

// File: rtl/thermal_guard_classifier.sv
// Combinational three-way split of a temperature sample against two thresholds.
module temp_classifier
  import thermal_guard_pkg::*;
#(
  parameter int TEMP_W = 8
) (
  input  logic [TEMP_W-1:0] temp,
  input  logic [TEMP_W-1:0] hot_thresh,
  input  logic [TEMP_W-1:0] cool_thresh,
  output sample_class_t     sample_class
);

  always_comb begin
    sample_class = CLS_BAND;
    if (temp >= hot_thresh) begin
      sample_class = CLS_HOT;
    end else if (temp < cool_thresh) begin
      sample_class = CLS_COOL;
    end
  end

endmodule

// File: rtl/thermal_guard.sv
// Debounced, hysteresis-filtered overheat flag plus a sticky shutdown request.
//   state      | meaning
//   NORMAL     | no hot run in progress
//   PENDING    | counting consecutive hot samples
//   OVERHEATED | overheat declared, waiting for a cool sample
//   COOLING    | counting consecutive cool samples
module thermal_guard
  import thermal_guard_pkg::*;
#(
  parameter int TEMP_W       = 8,
  parameter int HOT_THRESH   = 85,
  parameter int COOL_THRESH  = 75,
  parameter int HOT_SAMPLES  = 4,
  parameter int COOL_SAMPLES = 8
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp,
  input  logic              shutdown_ack,
  output logic              cpu_overheated,
  output logic              shut_off_computer,
  output logic [1:0]        guard_state,
  output logic [7:0]        overheat_count
);

  localparam int MAX_SAMPLES = (HOT_SAMPLES > COOL_SAMPLES) ? HOT_SAMPLES : COOL_SAMPLES;
  localparam int CNT_W       = $clog2(MAX_SAMPLES + 1);

  localparam logic [CNT_W-1:0] HOT_LAST  = CNT_W'(HOT_SAMPLES);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  guard_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             set_evt;
  sample_class_t    sample_class;

  temp_classifier #(.TEMP_W(TEMP_W)) u_classifier (
    .temp         (temp),
    .hot_thresh   (TEMP_W'(HOT_THRESH)),
    .cool_thresh  (TEMP_W'(COOL_THRESH)),
    .sample_class (sample_class)
  );

  assign cnt_inc = cnt + CNT_ONE;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    set_evt   = 1'b0;
    if (temp_valid) begin
      case (state)
        NORMAL: begin
          if (sample_class == CLS_HOT) begin
            if (HOT_SAMPLES == 1) begin
              state_nxt = OVERHEATED;
              cnt_nxt   = '0;
              set_evt   = 1'b1;
            end else begin
              state_nxt = PENDING;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        PENDING: begin
          if (sample_class == CLS_HOT) begin
            if (cnt_inc == HOT_LAST) begin
              state_nxt = OVERHEATED;
              cnt_nxt   = '0;
              set_evt   = 1'b1;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            state_nxt = NORMAL;
            cnt_nxt   = '0;
          end
        end
        OVERHEATED: begin
          if (sample_class == CLS_COOL) begin
            if (COOL_SAMPLES == 1) begin
              state_nxt = NORMAL;
              cnt_nxt   = '0;
            end else begin
              state_nxt = COOLING;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        default: begin
          // COOLING: any non-cool sample breaks the cool run
          if (sample_class == CLS_COOL) begin
            if (cnt_inc == COOL_LAST) begin
              state_nxt = NORMAL;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            state_nxt = OVERHEATED;
            cnt_nxt   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state             <= NORMAL;
      cnt               <= '0;
      shut_off_computer <= 1'b0;
      overheat_count    <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (set_evt) begin
        shut_off_computer <= 1'b1;
      end else if (shutdown_ack && (state == NORMAL || state == PENDING)) begin
        shut_off_computer <= 1'b0;
      end
      if (set_evt && overheat_count != 8'hFF) begin
        overheat_count <= overheat_count + 8'd1;
      end
    end
  end

  assign cpu_overheated = (state == OVERHEATED) || (state == COOLING);
  assign guard_state    = state;

endmodule
